// File: rtl/qdb_pkg.sv
// Shared types for the ball engine: game state, direction bits and display colours.
package qdb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_MISS = 2'd2,
        ST_OVER = 2'd3
    } game_state_t;

    // Direction: bit1 set = moving up, bit0 set = moving left.
    typedef logic [1:0] dir_t;
    localparam int   DIR_UP         = 1;
    localparam int   DIR_LEFT       = 0;
    localparam dir_t DIR_DOWN_RIGHT = 2'b00;

    localparam logic [11:0] COLOUR_BG     = 12'h000;
    localparam logic [11:0] COLOUR_WALL   = 12'h888;
    localparam logic [11:0] COLOUR_BALL   = 12'hFFF;
    localparam logic [11:0] COLOUR_PADDLE = 12'h0F0;

endpackage

// File: rtl/ball_collide.sv
// Combinational next-position evaluator: candidate step, wall clamp, paddle
// reflection and bottom-edge miss detection for one frame.
module ball_collide
    import qdb_pkg::*;
#(
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480,
    parameter int BORDER    = 8,
    parameter int BALL_SIZE = 8,
    parameter int PADDLE_Y  = 460,
    parameter int PADDLE_W  = 64
) (
    input  logic [9:0] ball_x,
    input  logic [9:0] ball_y,
    input  dir_t       dir,
    input  logic [9:0] paddle_x,
    input  logic [3:0] sx,
    input  logic [3:0] sy,
    output logic [9:0] next_x,
    output logic [9:0] next_y,
    output dir_t       next_dir,
    output logic       hit,
    output logic       miss
);

    localparam logic signed [10:0] X_MIN   = 11'(BORDER);
    localparam logic signed [10:0] X_MAX   = 11'(H_ACTIVE - BORDER - BALL_SIZE);
    localparam logic signed [10:0] Y_MIN   = 11'(BORDER);
    localparam logic signed [10:0] SZ      = 11'(BALL_SIZE);
    localparam logic signed [10:0] PAD_Y   = 11'(PADDLE_Y);
    localparam logic signed [10:0] PAD_W   = 11'(PADDLE_W);
    localparam logic signed [10:0] PAD_TOP = 11'(PADDLE_Y - BALL_SIZE);
    localparam logic signed [10:0] BOTTOM  = 11'(V_ACTIVE);
    localparam logic signed [10:0] Y_CLAMP = 11'(V_ACTIVE - BALL_SIZE);

    logic signed [10:0] bx, by, px, dx, dy, cx, cy;
    logic over_x, above, reach;

    // One extra sign bit lets a step past the left/top wall go negative instead of wrapping.
    assign bx = {1'b0, ball_x};
    assign by = {1'b0, ball_y};
    assign px = {1'b0, paddle_x};
    assign dx = {7'b0, sx};
    assign dy = {7'b0, sy};
    assign cx = dir[DIR_LEFT] ? (bx - dx) : (bx + dx);
    assign cy = dir[DIR_UP]   ? (by - dy) : (by + dy);

    assign over_x = (bx + SZ > px) && (bx < px + PAD_W);
    assign above  = (by + SZ <= PAD_Y);
    assign reach  = (cy + SZ >= PAD_Y);

    always_comb begin
        next_x   = cx[9:0];
        next_y   = cy[9:0];
        next_dir = dir;
        hit      = 1'b0;
        miss     = 1'b0;

        if (cx < X_MIN) begin
            next_x             = X_MIN[9:0];
            next_dir[DIR_LEFT] = 1'b0;
        end else if (cx > X_MAX) begin
            next_x             = X_MAX[9:0];
            next_dir[DIR_LEFT] = 1'b1;
        end

        if (dir[DIR_UP]) begin
            if (cy < Y_MIN) begin
                next_y           = Y_MIN[9:0];
                next_dir[DIR_UP] = 1'b0;
            end
        end else if (reach && above && over_x) begin
            next_y           = PAD_TOP[9:0];
            next_dir[DIR_UP] = 1'b1;
            hit              = 1'b1;
        end else if (cy + SZ >= BOTTOM) begin
            next_y = Y_CLAMP[9:0];
            miss   = 1'b1;
        end
    end

endmodule

// File: rtl/ball_engine.sv
// Ball game engine: frame-stepped FSM, ball registers, lives and miss hold-off.
// Optional BALL_SPEEDUP_EN adds a saturating speed level bumped on each paddle hit.
module ball_engine
    import qdb_pkg::*;
#(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int BORDER      = 8,
    parameter int BALL_SIZE   = 8,
    parameter int PADDLE_Y    = 460,
    parameter int PADDLE_W    = 64,
    parameter int STEP_X      = 1,
    parameter int STEP_Y      = 2,
    parameter int LIVES       = 3,
    parameter int MISS_FRAMES = 60
) (
    input  logic       pxl_clk,
    input  logic       reset_n,
    input  logic       frame_tick,
    input  logic       serve,
    input  logic [9:0] paddle_x,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic [1:0] game_state,
    output logic [2:0] lives,
    output logic       hit
);

    localparam logic [9:0] SERVE_X = 10'((H_ACTIVE - BALL_SIZE) / 2);
    localparam logic [9:0] SERVE_Y = 10'(V_ACTIVE / 2);
    localparam int         MW      = $clog2(MISS_FRAMES + 1);
    localparam logic [MW-1:0] MISS_LAST = MW'(MISS_FRAMES - 1);

    game_state_t   state_q, state_d;
    dir_t          dir_q, dir_d;
    logic [9:0]    x_d, y_d;
    logic [2:0]    lives_d;
    logic [MW-1:0] cnt_q, cnt_d;
    logic          hit_d;
    logic [3:0]    sx, sy;
    logic [9:0]    col_x, col_y;
    dir_t          col_dir;
    logic          col_hit, col_miss;

`ifdef BALL_SPEEDUP_EN
    logic [1:0] level_q, level_d;
    assign sx = 4'(STEP_X) + {2'b0, level_q};
    assign sy = 4'(STEP_Y) + {2'b0, level_q};
`else
    assign sx = 4'(STEP_X);
    assign sy = 4'(STEP_Y);
`endif

    ball_collide #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .BORDER   (BORDER),
        .BALL_SIZE(BALL_SIZE),
        .PADDLE_Y (PADDLE_Y),
        .PADDLE_W (PADDLE_W)
    ) u_collide (
        .ball_x  (ball_x),
        .ball_y  (ball_y),
        .dir     (dir_q),
        .paddle_x(paddle_x),
        .sx      (sx),
        .sy      (sy),
        .next_x  (col_x),
        .next_y  (col_y),
        .next_dir(col_dir),
        .hit     (col_hit),
        .miss    (col_miss)
    );

    assign game_state = state_q;

    always_ff @(posedge pxl_clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            dir_q   <= DIR_DOWN_RIGHT;
            ball_x  <= SERVE_X;
            ball_y  <= SERVE_Y;
            lives   <= 3'(LIVES);
            cnt_q   <= '0;
            hit     <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            ball_x  <= x_d;
            ball_y  <= y_d;
            lives   <= lives_d;
            cnt_q   <= cnt_d;
            hit     <= hit_d;
        end
    end

`ifdef BALL_SPEEDUP_EN
    always_ff @(posedge pxl_clk) begin
        if (!reset_n) level_q <= '0;
        else          level_q <= level_d;
    end
`endif

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        x_d     = ball_x;
        y_d     = ball_y;
        lives_d = lives;
        cnt_d   = cnt_q;
        hit_d   = 1'b0;
`ifdef BALL_SPEEDUP_EN
        level_d = level_q;
`endif
        if (frame_tick) begin
            unique case (state_q)
                ST_IDLE: begin
                    x_d = SERVE_X;
                    y_d = SERVE_Y;
                    if (serve) begin
                        state_d = ST_PLAY;
                        dir_d   = DIR_DOWN_RIGHT;
                    end
                end
                ST_PLAY: begin
                    x_d   = col_x;
                    y_d   = col_y;
                    dir_d = col_dir;
                    if (col_hit) begin
                        hit_d = 1'b1;
`ifdef BALL_SPEEDUP_EN
                        if (level_q != 2'd3) level_d = level_q + 2'd1;
`endif
                    end else if (col_miss) begin
                        state_d = ST_MISS;
                        lives_d = lives - 3'd1;
                        cnt_d   = '0;
`ifdef BALL_SPEEDUP_EN
                        level_d = '0;
`endif
                    end
                end
                ST_MISS: begin
                    if (cnt_q == MISS_LAST) begin
                        cnt_d = '0;
                        if (lives == 3'd0) begin
                            state_d = ST_OVER;
                        end else begin
                            state_d = ST_IDLE;
                            x_d     = SERVE_X;
                            y_d     = SERVE_Y;
                            dir_d   = DIR_DOWN_RIGHT;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_OVER: begin
                    if (serve) begin
                        state_d = ST_IDLE;
                        lives_d = 3'(LIVES);
                        x_d     = SERVE_X;
                        y_d     = SERVE_Y;
                        dir_d   = DIR_DOWN_RIGHT;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ball_engine.sv
// Scoreboard bench for ball_engine (default build): expected outputs queued per frame tick.
module tb_ball_engine;

    logic       pxl_clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic       serve = 1'b0;
    logic [9:0] paddle_x = '0;
    logic [9:0] ball_x, ball_y;
    logic [1:0] game_state;
    logic [2:0] lives;
    logic       hit;

    typedef struct {
        bit         chk;
        logic [1:0] st;
        logic [9:0] x;
        logic [9:0] y;
        logic [2:0] lv;
        logic       h;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    logic presented = 1'b0;
    bit   hit_follow = 1'b0;

    ball_engine #(
        .H_ACTIVE   (640),
        .V_ACTIVE   (480),
        .BORDER     (8),
        .BALL_SIZE  (8),
        .PADDLE_Y   (460),
        .PADDLE_W   (64),
        .STEP_X     (1),
        .STEP_Y     (2),
        .LIVES      (3),
        .MISS_FRAMES(60)
    ) dut (
        .pxl_clk   (pxl_clk),
        .reset_n   (reset_n),
        .frame_tick(frame_tick),
        .serve     (serve),
        .paddle_x  (paddle_x),
        .ball_x    (ball_x),
        .ball_y    (ball_y),
        .game_state(game_state),
        .lives     (lives),
        .hit       (hit)
    );

    always #5 pxl_clk = ~pxl_clk;

    always @(posedge pxl_clk) presented <= frame_tick && reset_n;

    // Monitor: every accepted frame tick presents one output vector.
    always @(negedge pxl_clk) begin
        if (hit_follow) begin
            hit_follow = 1'b0;
            vectors++;
            if (hit !== 1'b0) begin
                miscompares++;
                $display("FAIL hit_width: hit=%0b one cycle after pulse, required 0", hit);
            end
        end
        if (presented) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_tick: output presented with empty scoreboard");
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (e.chk) begin
                    vectors++;
                    if ({game_state, ball_x, ball_y, lives, hit} !== {e.st, e.x, e.y, e.lv, e.h}) begin
                        miscompares++;
                        $display("FAIL frame_vec: got st=%0d x=%0d y=%0d lives=%0d hit=%0b, required st=%0d x=%0d y=%0d lives=%0d hit=%0b",
                                 game_state, ball_x, ball_y, lives, hit, e.st, e.x, e.y, e.lv, e.h);
                    end
                    if (e.h) hit_follow = 1'b1;
                end
            end
        end
    end

    task automatic pulse(input logic srv, input logic [9:0] pad, input exp_t e);
        sb.push_back(e);
        serve      = srv;
        paddle_x   = pad;
        frame_tick = 1'b1;
        @(posedge pxl_clk); #1;
        frame_tick = 1'b0;
        @(posedge pxl_clk); #1;
        @(posedge pxl_clk); #1;
    endtask

    task automatic run(input int n, input logic srv, input logic [9:0] pad);
        exp_t e;
        e = '{chk: 1'b0, st: 2'd0, x: 10'd0, y: 10'd0, lv: 3'd0, h: 1'b0};
        for (int i = 0; i < n; i++) pulse(srv, pad, e);
    endtask

    task automatic tick_chk(input logic srv, input logic [9:0] pad, input logic [1:0] st,
                            input int x, input int y, input int lv, input logic h);
        exp_t e;
        e = '{chk: 1'b1, st: st, x: 10'(x), y: 10'(y), lv: 3'(lv), h: h};
        pulse(srv, pad, e);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        repeat (3) @(posedge pxl_clk);
        #1 reset_n = 1'b1;
        @(posedge pxl_clk); #1;

        // Reset state, then serve: ball stays centred on the launching tick.
        tick_chk(1'b0, 10'd400, 2'd0, 316, 240, 3, 1'b0);
        tick_chk(1'b1, 10'd400, 2'd1, 316, 240, 3, 1'b0);

        // Descend down-right onto the paddle at x=400.
        tick_chk(1'b0, 10'd400, 2'd1, 317, 242, 3, 1'b0);
        run(104, 1'b0, 10'd400);
        tick_chk(1'b0, 10'd400, 2'd1, 422, 452, 3, 1'b1);

        // Up-right to the right wall clamp at 624, then up-left.
        run(201, 1'b0, 10'd400);
        tick_chk(1'b0, 10'd400, 2'd1, 624, 48, 3, 1'b0);
        tick_chk(1'b0, 10'd400, 2'd1, 624, 46, 3, 1'b0);
        tick_chk(1'b0, 10'd400, 2'd1, 623, 44, 3, 1'b0);

        // Top wall: exact landing on 8, then a clamped step reflects downward.
        run(17, 1'b0, 10'd400);
        tick_chk(1'b0, 10'd400, 2'd1, 605, 8, 3, 1'b0);
        tick_chk(1'b0, 10'd400, 2'd1, 604, 8, 3, 1'b0);
        tick_chk(1'b0, 10'd400, 2'd1, 603, 10, 3, 1'b0);

        // Down-left past the paddle edge (no overlap), then miss at the bottom.
        run(220, 1'b0, 10'd400);
        tick_chk(1'b0, 10'd400, 2'd1, 382, 452, 3, 1'b0);
        run(9, 1'b0, 10'd400);
        tick_chk(1'b0, 10'd400, 2'd2, 372, 472, 2, 1'b0);

        // Miss hold-off: frozen for 59 ticks, back to IDLE on the 60th.
        run(58, 1'b0, 10'd400);
        tick_chk(1'b0, 10'd400, 2'd2, 372, 472, 2, 1'b0);
        tick_chk(1'b0, 10'd400, 2'd0, 316, 240, 2, 1'b0);

        // Second ball with paddle at 0: falls straight through.
        tick_chk(1'b1, 10'd0, 2'd1, 316, 240, 2, 1'b0);
        run(114, 1'b0, 10'd0);
        tick_chk(1'b0, 10'd0, 2'd1, 431, 470, 2, 1'b0);
        tick_chk(1'b0, 10'd0, 2'd2, 432, 472, 1, 1'b0);
        run(59, 1'b0, 10'd0);
        tick_chk(1'b0, 10'd0, 2'd0, 316, 240, 1, 1'b0);

        // Last ball: OVER keeps the ball frozen until serve reloads lives.
        tick_chk(1'b1, 10'd0, 2'd1, 316, 240, 1, 1'b0);
        run(115, 1'b0, 10'd0);
        tick_chk(1'b0, 10'd0, 2'd2, 432, 472, 0, 1'b0);
        run(59, 1'b0, 10'd0);
        tick_chk(1'b0, 10'd0, 2'd3, 432, 472, 0, 1'b0);
        tick_chk(1'b0, 10'd0, 2'd3, 432, 472, 0, 1'b0);
        tick_chk(1'b1, 10'd0, 2'd0, 316, 240, 3, 1'b0);

        // Reset in the middle of play, coinciding with a frame tick.
        tick_chk(1'b1, 10'd0, 2'd1, 316, 240, 3, 1'b0);
        tick_chk(1'b0, 10'd0, 2'd1, 317, 242, 3, 1'b0);
        tick_chk(1'b0, 10'd0, 2'd1, 318, 244, 3, 1'b0);
        frame_tick = 1'b1;
        reset_n    = 1'b0;
        repeat (2) @(posedge pxl_clk);
        #1 frame_tick = 1'b0;
        reset_n = 1'b1;
        @(posedge pxl_clk); #1;
        tick_chk(1'b0, 10'd0, 2'd0, 316, 240, 3, 1'b0);
        tick_chk(1'b1, 10'd0, 2'd1, 316, 240, 3, 1'b0);
        tick_chk(1'b0, 10'd0, 2'd1, 317, 242, 3, 1'b0);

        for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge pxl_clk);
        if (sb.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: %0d expected vectors never presented, required 0", sb.size());
        end
        repeat (3) @(posedge pxl_clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
